// File: rtl/jtkunio_gfx_slots_pkg.sv
// Shared types and constants for the kunio two-slot graphics SDRAM read port.
// Lines are 32 bits wide, assembled from two 16-bit SDRAM beats.
package jtkunio_gfx_pkg;

    localparam int SDRAM_AW   = 22;
    localparam int BEAT_W     = 16;
    localparam int FILL_BEATS = 2;
    localparam int LINE_W     = BEAT_W * FILL_BEATS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    function automatic logic [BEAT_W-1:0] swab_beat(input logic [BEAT_W-1:0] b);
        return {b[7:0], b[15:8]};
    endfunction

endpackage

// File: rtl/jtkunio_gfx_slots_if.sv
// SDRAM bank read port: the top drives the request side (master), the
// SDRAM controller answers with ack and data beats (slave).
interface jtkunio_gfx_slots_if;
    import jtkunio_gfx_pkg::*;

    logic [SDRAM_AW-1:0] sdram_addr;
    logic                sdram_req;
    logic                sdram_ack;
    logic                data_dst;
    logic                data_rdy;
    logic [BEAT_W-1:0]   data_read;

    modport master (
        output sdram_addr, sdram_req,
        input  sdram_ack, data_dst, data_rdy, data_read
    );

    modport slave (
        input  sdram_addr, sdram_req,
        output sdram_ack, data_dst, data_rdy, data_read
    );
endinterface

// File: rtl/jtkunio_gfx_slots_cache_line.sv
// One-entry cache for a single graphics slot: tag compare, two-beat line
// assembly with optional byte swap, and flush/discard handling of the valid bit.
module jtkunio_gfx_cache_line
    import jtkunio_gfx_pkg::*;
#(
    parameter int AW   = 14,
    parameter bit SWAB = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cs,
    input  logic [AW-1:0]     addr,
    output logic              ok,
    output logic [LINE_W-1:0] dout,
    input  logic              beat_we,
    input  logic              beat_last,
    input  logic [BEAT_W-1:0] beat,
    input  logic [AW-1:0]     fill_addr,
    input  logic              discard
);

    logic [AW-1:0]     r_addr;
    logic [LINE_W-1:0] r_data;
    logic              r_valid;
    logic [BEAT_W-1:0] r_lo;
    logic [BEAT_W-1:0] w_beat;

    assign w_beat = SWAB ? swab_beat(beat) : beat;
    assign ok     = cs & r_valid & (addr == r_addr);
    assign dout   = r_data;

    // The low beat is staged so dout only changes once the whole line is in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_lo    <= '0;
        end else begin
            if (beat_we && !beat_last) begin
                r_lo <= w_beat;
            end
            if (beat_we && beat_last) begin
                r_data  <= {w_beat, r_lo};
                r_addr  <= fill_addr;
                r_valid <= !discard;
            end
            // NOTE: the later non-blocking write wins, so a flush landing on the
            // completing beat still leaves the entry invalid.
            if (flush) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtkunio_gfx_slots.sv
// Two-slot SDRAM read port for one kunio graphics bank: round-robin miss
// arbitration, a single outstanding two-beat fill, one cache line per slot.
module jtkunio_gfx_slots
    import jtkunio_gfx_pkg::*;
#(
    parameter int                  SLOT0_AW     = 14,
    parameter int                  SLOT1_AW     = 17,
    parameter logic [SDRAM_AW-1:0] SLOT0_OFFSET = 22'h0,
    parameter logic [SDRAM_AW-1:0] SLOT1_OFFSET = 22'h0,
    parameter bit                  SWAB         = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,

    input  logic                slot0_cs,
    input  logic [SLOT0_AW-1:0] slot0_addr,
    output logic                slot0_ok,
    output logic [LINE_W-1:0]   slot0_dout,

    input  logic                slot1_cs,
    input  logic [SLOT1_AW-1:0] slot1_addr,
    output logic                slot1_ok,
    output logic [LINE_W-1:0]   slot1_dout,

    jtkunio_gfx_slots_if.master bus
);

    localparam int MAX_AW = (SLOT0_AW > SLOT1_AW) ? SLOT0_AW : SLOT1_AW;

    state_t              r_state;
    logic                r_rr;
    logic                r_gnt;
    logic                r_discard;
    logic [MAX_AW-1:0]   r_fill_addr;

    logic                w_miss0;
    logic                w_miss1;
    logic                w_pick_valid;
    logic                w_pick;
    logic [SDRAM_AW-1:0] w_sd_addr0;
    logic [SDRAM_AW-1:0] w_sd_addr1;
    logic                w_fill_beat;
    logic                w_fill_last;

    assign w_miss0    = slot0_cs & ~slot0_ok;
    assign w_miss1    = slot1_cs & ~slot1_ok;
    assign w_sd_addr0 = SLOT0_OFFSET + SDRAM_AW'({slot0_addr, 1'b0});
    assign w_sd_addr1 = SLOT1_OFFSET + SDRAM_AW'({slot1_addr, 1'b0});

    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = 1'b0;
        if (w_miss0 && w_miss1) begin
            w_pick = r_rr;
        end else if (w_miss1) begin
            w_pick = 1'b1;
        end
        w_pick_valid = (w_miss0 | w_miss1) & ~flush;
    end

    assign w_fill_beat = (r_state == WAIT_DATA) & bus.data_dst;
    assign w_fill_last = w_fill_beat & bus.data_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_rr           <= 1'b0;
            r_gnt          <= 1'b0;
            r_discard      <= 1'b0;
            r_fill_addr    <= '0;
            bus.sdram_req  <= 1'b0;
            bus.sdram_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_discard <= 1'b0;
                    if (w_pick_valid) begin
                        r_gnt          <= w_pick;
                        r_rr           <= ~w_pick;
                        r_fill_addr    <= w_pick ? MAX_AW'(slot1_addr) : MAX_AW'(slot0_addr);
                        bus.sdram_addr <= w_pick ? w_sd_addr1 : w_sd_addr0;
                        bus.sdram_req  <= 1'b1;
                        r_state        <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (flush) begin
                        r_discard <= 1'b1;
                    end
                    if (bus.sdram_ack) begin
                        bus.sdram_req <= 1'b0;
                        r_state       <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (flush) begin
                        r_discard <= 1'b1;
                    end
                    if (w_fill_last) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    bus.sdram_req <= 1'b0;
                end
            endcase
        end
    end

    jtkunio_gfx_cache_line #(
        .AW   (SLOT0_AW),
        .SWAB (SWAB)
    ) u_line0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .cs        (slot0_cs),
        .addr      (slot0_addr),
        .ok        (slot0_ok),
        .dout      (slot0_dout),
        .beat_we   (w_fill_beat & ~r_gnt),
        .beat_last (bus.data_rdy),
        .beat      (bus.data_read),
        .fill_addr (r_fill_addr[SLOT0_AW-1:0]),
        .discard   (r_discard)
    );

    jtkunio_gfx_cache_line #(
        .AW   (SLOT1_AW),
        .SWAB (SWAB)
    ) u_line1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .cs        (slot1_cs),
        .addr      (slot1_addr),
        .ok        (slot1_ok),
        .dout      (slot1_dout),
        .beat_we   (w_fill_beat & r_gnt),
        .beat_last (bus.data_rdy),
        .beat      (bus.data_read),
        .fill_addr (r_fill_addr[SLOT1_AW-1:0]),
        .discard   (r_discard)
    );

endmodule

// File: tb/tb_jtkunio_gfx_slots.sv
// Bench for jtkunio_gfx_slots: directed scenarios plus a randomized run checked
// against a per-slot cache model and a synthetic SDRAM content function.
module tb_jtkunio_gfx_slots;

    localparam logic [21:0] OFF0 = 22'h0;
    localparam logic [21:0] OFF1 = 22'h10000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        cs0   = 1'b0;
    logic        cs1   = 1'b0;
    logic [13:0] a0    = '0;
    logic [16:0] a1    = '0;

    logic        ok0, ok1, sok0, sok1;
    logic [31:0] d0, d1, sd0, sd1;

    jtkunio_gfx_slots_if bus();
    jtkunio_gfx_slots_if sbus();

    assign sbus.sdram_ack = bus.sdram_ack;
    assign sbus.data_dst  = bus.data_dst;
    assign sbus.data_rdy  = bus.data_rdy;
    assign sbus.data_read = bus.data_read;

    jtkunio_gfx_slots #(
        .SLOT0_AW(14), .SLOT1_AW(17), .SLOT0_OFFSET(OFF0), .SLOT1_OFFSET(OFF1), .SWAB(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .slot0_cs(cs0), .slot0_addr(a0), .slot0_ok(ok0), .slot0_dout(d0),
        .slot1_cs(cs1), .slot1_addr(a1), .slot1_ok(ok1), .slot1_dout(d1),
        .bus(bus)
    );

    jtkunio_gfx_slots #(
        .SLOT0_AW(14), .SLOT1_AW(17), .SLOT0_OFFSET(OFF0), .SLOT1_OFFSET(OFF1), .SWAB(1'b1)
    ) u_swab (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .slot0_cs(cs0), .slot0_addr(a0), .slot0_ok(sok0), .slot0_dout(sd0),
        .slot1_cs(cs1), .slot1_addr(a1), .slot1_ok(sok1), .slot1_dout(sd1),
        .bus(sbus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what each slot's cache line should hold.
    bit          m_valid [2];
    logic [16:0] m_addr  [2];
    logic [31:0] m_data  [2];
    bit          m_rr;

    function automatic logic [15:0] mem16(input logic [21:0] a);
        logic [15:0] x;
        x = a[15:0] ^ {a[21:16], a[21:12]};
        return 16'(x * 16'h9E37 + 16'h1357);
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[23:16], w[31:24], w[7:0], w[15:8]};
    endfunction

    function automatic logic [21:0] sd_addr(input int slot, input logic [16:0] a);
        if (slot == 0) return OFF0 + 22'(a[13:0]) * 22'd2;
        return OFF1 + 22'(a) * 22'd2;
    endfunction

    function automatic bit m_hit(input int s);
        if (s == 0) return cs0 && m_valid[0] && (m_addr[0] == 17'(a0));
        return cs1 && m_valid[1] && (m_addr[1] == a1);
    endfunction

    function automatic int m_pick();
        bit miss0, miss1;
        miss0 = cs0 && !m_hit(0);
        miss1 = cs1 && !m_hit(1);
        if (flush || !(miss0 || miss1)) return -1;
        if (miss0 && miss1) return m_rr ? 1 : 0;
        return miss0 ? 0 : 1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            m_valid[s] = 1'b0;
            m_addr[s]  = '0;
            m_data[s]  = '0;
        end
        m_rr = 1'b0;
    endtask

    task automatic model_fill(input int s, input logic [16:0] a, input logic [15:0] lo,
                              input logic [15:0] hi, input bit keep);
        m_valid[s] = keep;
        m_addr[s]  = a;
        m_data[s]  = {hi, lo};
        m_rr       = (s == 0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        cs0 = 1'b0; cs1 = 1'b0; flush = 1'b0;
        bus.sdram_ack = 1'b0; bus.data_dst = 1'b0; bus.data_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    // SDRAM controller behaviour for one fill; optional events happen mid-fill.
    // mid_action: 1 = move the granted slot's address, 2 = drop its cs.
    task automatic serve(input int slot, input logic [21:0] exp_addr,
                         input logic [15:0] lo, input logic [15:0] hi,
                         input int exp_wait, input int d_ack, input int g1, input int g2,
                         input bit flush_at_ack, input int mid_action, input logic [16:0] mid_addr);
        int n;
        n = 0;
        while (bus.sdram_req !== 1'b1 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout slot %0d got req %b exp 1", slot, bus.sdram_req);
            return;
        end
        if (exp_wait > 0) begin
            checks++;
            if (n != exp_wait) begin
                errors++;
                $display("FAIL req_latency slot %0d got %0d cycles exp %0d", slot, n, exp_wait);
            end
        end
        checks++;
        if (bus.sdram_addr !== exp_addr) begin
            errors++;
            $display("FAIL sdram_addr slot %0d got %h exp %h", slot, bus.sdram_addr, exp_addr);
        end
        if (flush_at_ack) flush = 1'b1;
        for (int i = 0; i < d_ack; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== exp_addr) begin
                errors++;
                $display("FAIL req_hold got req %b addr %h exp 1 %h", bus.sdram_req, bus.sdram_addr, exp_addr);
            end
        end
        bus.sdram_ack = 1'b1;
        @(posedge clk); #1;
        bus.sdram_ack = 1'b0;
        checks++;
        if (bus.sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL req_drop got %b exp 0", bus.sdram_req);
        end
        repeat (g1) begin @(posedge clk); #1; end
        bus.data_dst = 1'b1; bus.data_read = lo;
        @(posedge clk); #1;
        bus.data_dst = 1'b0; bus.data_read = 16'($urandom);
        if (mid_action == 1) begin
            if (slot == 0) a0 = mid_addr[13:0]; else a1 = mid_addr;
        end else if (mid_action == 2) begin
            if (slot == 0) cs0 = 1'b0; else cs1 = 1'b0;
        end
        repeat (g2) begin @(posedge clk); #1; end
        bus.data_dst = 1'b1; bus.data_rdy = 1'b1; bus.data_read = hi;
        @(posedge clk); #1;
        bus.data_dst = 1'b0; bus.data_rdy = 1'b0; bus.data_read = 16'($urandom);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        cs0 = 1'b1; a0 = '0; cs1 = 1'b1; a1 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.sdram_req !== 1'b0 || bus.sdram_addr !== 22'h0) begin
            errors++;
            $display("FAIL reset_bus got req %b addr %h exp 0 0", bus.sdram_req, bus.sdram_addr);
        end
        checks++;
        if (ok0 !== 1'b0 || ok1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ok got %b%b exp 00", ok0, ok1);
        end
        checks++;
        if (d0 !== 32'h0 || d1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_dout got %h %h exp 0 0", d0, d1);
        end
        cs0 = 1'b0; cs1 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_basic();
        apply_reset();
        cs0 = 1'b1; a0 = 14'h0005;
        serve(0, 22'h00000A, 16'h1234, 16'h5678, 1, 0, 0, 0, 1'b0, 0, '0);
        model_fill(0, 17'h5, 16'h1234, 16'h5678, 1'b1);
        @(negedge clk);
        checks++;
        if (ok0 !== 1'b1 || d0 !== 32'h5678_1234) begin
            errors++;
            $display("FAIL basic_fill got ok %b dout %h exp 1 56781234", ok0, d0);
        end
        checks++;
        if (sok0 !== 1'b1 || sd0 !== 32'h7856_3412) begin
            errors++;
            $display("FAIL basic_swab got ok %b dout %h exp 1 78563412", sok0, sd0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.sdram_req !== 1'b0 || sbus.sdram_req !== 1'b0 || ok0 !== 1'b1) begin
                errors++;
                $display("FAIL basic_hit got req %b ok %b exp 0 1", bus.sdram_req, ok0);
            end
        end
    endtask

    task automatic test_simul();
        logic [15:0] l0, h0, l1, h1;
        apply_reset();
        l0 = mem16(22'h6);     h0 = mem16(22'h7);
        l1 = mem16(22'h1000E); h1 = mem16(22'h1000F);
        cs0 = 1'b1; a0 = 14'd3; cs1 = 1'b1; a1 = 17'd7;
        serve(0, 22'h000006, l0, h0, 1, 1, 1, 0, 1'b0, 0, '0);
        model_fill(0, 17'd3, l0, h0, 1'b1);
        @(negedge clk);
        checks++;
        if (ok0 !== 1'b1 || ok1 !== 1'b0) begin
            errors++;
            $display("FAIL simul_first got ok0 %b ok1 %b exp 1 0", ok0, ok1);
        end
        serve(1, 22'h1000E, l1, h1, 1, 0, 0, 1, 1'b0, 0, '0);
        model_fill(1, 17'd7, l1, h1, 1'b1);
        @(negedge clk);
        checks++;
        if (ok0 !== 1'b1 || ok1 !== 1'b1 || d0 !== {h0, l0} || d1 !== {h1, l1}) begin
            errors++;
            $display("FAIL simul_both got ok %b%b d0 %h d1 %h exp 11 %h %h", ok0, ok1, d0, d1, {h0, l0}, {h1, l1});
        end
    endtask

    task automatic test_addr_change();
        logic [15:0] l5, h5, l6, h6;
        apply_reset();
        l5 = mem16(22'hA); h5 = mem16(22'hB);
        l6 = mem16(22'hC); h6 = mem16(22'hD);
        cs0 = 1'b1; a0 = 14'd5;
        serve(0, 22'h00000A, l5, h5, 1, 0, 0, 1, 1'b0, 1, 17'd6);
        model_fill(0, 17'd5, l5, h5, 1'b1);
        @(negedge clk);
        checks++;
        if (ok0 !== 1'b0 || d0 !== {h5, l5}) begin
            errors++;
            $display("FAIL addr_change_stale got ok %b dout %h exp 0 %h", ok0, d0, {h5, l5});
        end
        serve(0, 22'h00000C, l6, h6, 1, 0, 0, 0, 1'b0, 0, '0);
        model_fill(0, 17'd6, l6, h6, 1'b1);
        @(negedge clk);
        checks++;
        if (ok0 !== 1'b1 || d0 !== {h6, l6}) begin
            errors++;
            $display("FAIL addr_change_refetch got ok %b dout %h exp 1 %h", ok0, d0, {h6, l6});
        end
    endtask

    task automatic test_flush();
        logic [16:0] b;
        logic [13:0] x;
        logic [21:0] ea;
        apply_reset();
        b = 17'($urandom);
        x = 14'($urandom);
        cs1 = 1'b1; a1 = b;
        ea = sd_addr(1, b);
        serve(1, ea, mem16(ea), mem16(ea + 1), 1, 0, 0, 0, 1'b0, 0, '0);
        model_fill(1, b, mem16(ea), mem16(ea + 1), 1'b1);
        @(negedge clk);
        checks++;
        if (ok1 !== 1'b1) begin
            errors++;
            $display("FAIL flush_prefill got ok1 %b exp 1", ok1);
        end
        @(posedge clk); #1;
        cs1 = 1'b0; cs0 = 1'b1; a0 = x;
        ea = sd_addr(0, 17'(x));
        serve(0, ea, mem16(ea), mem16(ea + 1), 1, 1, 0, 0, 1'b1, 0, '0);
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (ok0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard got ok0 %b exp 0", ok0);
        end
        cs1 = 1'b1; a1 = b;
        #1;
        checks++;
        if (ok1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_other got ok1 %b exp 0", ok1);
        end
        cs1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.sdram_req !== 1'b0) begin
                errors++;
                $display("FAIL flush_block got req %b exp 0", bus.sdram_req);
            end
        end
        flush = 1'b0;
        serve(0, ea, mem16(ea), mem16(ea + 1), 1, 0, 0, 0, 1'b0, 0, '0);
        model_fill(0, 17'(x), mem16(ea), mem16(ea + 1), 1'b1);
        @(negedge clk);
        checks++;
        if (ok0 !== 1'b1 || d0 !== m_data[0]) begin
            errors++;
            $display("FAIL flush_refetch got ok %b dout %h exp 1 %h", ok0, d0, m_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] b;
        logic [21:0] ea;
        apply_reset();
        b = 17'($urandom);
        cs1 = 1'b1; a1 = b;
        ea = sd_addr(1, b);
        serve(1, ea, mem16(ea), mem16(ea + 1), 1, 0, 0, 0, 1'b0, 0, '0);
        cs0 = 1'b1; a0 = 14'h0123;
        @(posedge clk); #1;
        checks++;
        if (bus.sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req got %b exp 1", bus.sdram_req);
        end
        bus.sdram_ack = 1'b1;
        @(posedge clk); #1;
        bus.sdram_ack = 1'b0; bus.data_dst = 1'b1; bus.data_read = 16'hBEEF;
        @(posedge clk); #1;
        bus.data_dst = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sdram_req !== 1'b0 || bus.sdram_addr !== 22'h0 || ok0 !== 1'b0 || ok1 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got req %b addr %h ok %b%b exp 0 0 00", bus.sdram_req, bus.sdram_addr, ok0, ok1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; cs0 = 1'b0; cs1 = 1'b0;
        model_clear();
        @(posedge clk); #1;
        bus.data_dst = 1'b1; bus.data_rdy = 1'b1; bus.data_read = 16'hDEAD;
        @(posedge clk); #1;
        bus.data_dst = 1'b0; bus.data_rdy = 1'b0;
        cs0 = 1'b1; a0 = 14'h0;
        @(negedge clk);
        checks++;
        if (ok0 !== 1'b0 || d0 !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_stray got ok %b dout %h exp 0 0", ok0, d0);
        end
        serve(0, 22'h0, mem16(22'h0), mem16(22'h1), 1, 0, 0, 0, 1'b0, 0, '0);
        model_fill(0, 17'h0, mem16(22'h0), mem16(22'h1), 1'b1);
        @(negedge clk);
        checks++;
        if (ok0 !== 1'b1 || d0 !== m_data[0]) begin
            errors++;
            $display("FAIL rstmid_refetch got ok %b dout %h exp 1 %h", ok0, d0, m_data[0]);
        end
    endtask

    task automatic test_random();
        int p, act;
        logic [16:0] fa;
        logic [21:0] ea;
        logic [15:0] lo, hi;
        apply_reset();
        for (int it = 0; it < 80; it++) begin
            cs0 = ($urandom_range(0, 3) != 0);
            a0  = 14'($urandom_range(0, 3));
            cs1 = ($urandom_range(0, 3) != 0);
            a1  = 17'($urandom_range(0, 3)) + 17'h100;
            @(negedge clk);
            checks++;
            if (ok0 !== m_hit(0) || ok1 !== m_hit(1)) begin
                errors++;
                $display("FAIL rand_ok it %0d got %b%b exp %b%b", it, ok0, ok1, m_hit(0), m_hit(1));
            end
            checks++;
            if (d0 !== m_data[0] || d1 !== m_data[1] || sd0 !== swap32(m_data[0]) || sd1 !== swap32(m_data[1])) begin
                errors++;
                $display("FAIL rand_dout it %0d got %h %h exp %h %h", it, d0, d1, m_data[0], m_data[1]);
            end
            p = m_pick();
            if (p < 0) begin
                @(posedge clk); #1;
                checks++;
                if (bus.sdram_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle it %0d got req %b exp 0", it, bus.sdram_req);
                end
            end else begin
                fa  = (p == 0) ? 17'(a0) : a1;
                ea  = sd_addr(p, fa);
                lo  = mem16(ea);
                hi  = mem16(ea + 1);
                act = $urandom_range(0, 3);
                if (act == 3) act = 0;
                serve(p, ea, lo, hi, 1, $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 2), 1'b0, act, 17'($urandom_range(0, 3)) + 17'h100);
                model_fill(p, fa, lo, hi, 1'b1);
            end
        end
    endtask

    initial begin
        bus.sdram_ack = 1'b0; bus.data_dst = 1'b0; bus.data_rdy = 1'b0; bus.data_read = '0;
        test_reset();
        test_basic();
        test_simul();
        test_addr_change();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
